// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage pipelined floating-point multiplier.
//   Word layout {sign, exp[EXP_W-1:0], mant[MANT_W-1:0]}, MSB first, with an
//   implicit leading 1 on the mantissa. An operand with exp=0 and mant=0 is zero.
//   S1: decode (sign, zero flag, exponents, fractions {1,mant})
//   S2: fraction product and exponent sum
//   S3: normalise, round, range-check and register the result
// Optional feature macro: FP_MULT_ROUND_EN enables round-to-nearest-even on
//   the discarded product bits; without it those bits are truncated.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high (in_valid/in_ready at the input, out_valid/out_ready at the
//   output). When out_valid=1 and out_ready=0 every stage holds and
//   in_ready=0; in every other cycle in_ready=1 and all stages advance by one.
//   Valid bits travel with their data, so results leave in input order.

module fp_mult_pipe #(
  parameter int EXP_W  = 7,
  parameter int MANT_W = 16,
  parameter int BIAS   = 2**(EXP_W-1)-1,
  localparam int W     = 1 + EXP_W + MANT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] prod,
  output logic         ovf,
  output logic         unf
);

  // Fraction product width and widened exponent width (no wrap possible).
  localparam int P  = 2*MANT_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] BIAS_E = EW'(BIAS);

  // ------------------------------------------------------------------
  // Flow control: the only stall source is a held output.
  // ------------------------------------------------------------------
  logic advance;

  assign advance  = ~(out_valid & ~out_ready);
  assign in_ready = advance;

  // ------------------------------------------------------------------
  // Operand field decode
  // ------------------------------------------------------------------
  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [MANT_W-1:0] mant_a, mant_b;
  logic              zero_a, zero_b;

  assign sign_a = a[W-1];
  assign sign_b = b[W-1];
  assign exp_a  = a[W-2 -: EXP_W];
  assign exp_b  = b[W-2 -: EXP_W];
  assign mant_a = a[MANT_W-1:0];
  assign mant_b = b[MANT_W-1:0];
  assign zero_a = (a[W-2:0] == '0);
  assign zero_b = (b[W-2:0] == '0);

  // ------------------------------------------------------------------
  // Stage 1 registers
  // ------------------------------------------------------------------
  logic              s1_valid;
  logic              s1_sign;
  logic              s1_zero;
  logic [EXP_W-1:0]  s1_exp_a, s1_exp_b;
  logic [MANT_W:0]   s1_frac_a, s1_frac_b;

  // S1: capture decoded operands when a pair is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_exp_a  <= '0;
      s1_exp_b  <= '0;
      s1_frac_a <= '0;
      s1_frac_b <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign   <= sign_a ^ sign_b;
        s1_zero   <= zero_a | zero_b;
        s1_exp_a  <= exp_a;
        s1_exp_b  <= exp_b;
        s1_frac_a <= {1'b1, mant_a};
        s1_frac_b <= {1'b1, mant_b};
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 2 registers
  // ------------------------------------------------------------------
  logic          s2_valid;
  logic          s2_sign;
  logic          s2_zero;
  logic [EW-1:0] s2_exp_sum;
  logic [P-1:0]  s2_frac;

  // S2: full-width fraction product and raw exponent sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      s2_sign    <= 1'b0;
      s2_zero    <= 1'b0;
      s2_exp_sum <= '0;
      s2_frac    <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign    <= s1_sign;
        s2_zero    <= s1_zero;
        s2_exp_sum <= {2'b00, s1_exp_a} + {2'b00, s1_exp_b};
        s2_frac    <= P'(s1_frac_a) * P'(s1_frac_b);
      end
    end
  end

  // ------------------------------------------------------------------
  // Stage 3 datapath: normalise, round, range-check
  // ------------------------------------------------------------------
  logic              norm;
  logic [MANT_W-1:0] mant_n;
  logic              round_up;
  logic [MANT_W:0]   mant_r;
  logic [EW-1:0]     e_fin;
  logic [EW-1:0]     e_off;
  logic              under;
  logic              over;
  logic [W-1:0]      res;
  logic              res_ovf;
  logic              res_unf;

  // Both fractions are in [1,2), so the product is in [1,4): the leading one
  // sits in one of the top two bits and selects which mantissa window to keep.
  always_comb begin
    norm   = s2_frac[P-1];
    mant_n = norm ? s2_frac[P-2 -: MANT_W] : s2_frac[P-3 -: MANT_W];
  end

`ifdef FP_MULT_ROUND_EN
  logic guard;
  logic sticky;

  // Round to nearest, ties to even, on the bits below the kept window.
  always_comb begin
    guard    = norm ? s2_frac[P-2-MANT_W] : s2_frac[P-3-MANT_W];
    sticky   = norm ? (|s2_frac[P-3-MANT_W:0]) : (|s2_frac[P-4-MANT_W:0]);
    round_up = guard & (sticky | mant_n[0]);
  end
`else
  // Truncation: the bits below the kept window are simply dropped.
  logic unused_low_bits;

  assign unused_low_bits = |s2_frac[P-3-MANT_W:0];
  assign round_up        = 1'b0;
`endif

  // Exponent adjust and range checks; a rounding carry-out leaves the
  // mantissa at zero and bumps the exponent before the checks.
  always_comb begin
    mant_r  = {1'b0, mant_n} + {{MANT_W{1'b0}}, round_up};
    e_fin   = s2_exp_sum + {{(EW-1){1'b0}}, norm} + {{(EW-1){1'b0}}, mant_r[MANT_W]};
    under   = (e_fin < BIAS_E);
    e_off   = e_fin - BIAS_E;
    over    = |e_off[EW-1:EXP_W];
    res     = {s2_sign, e_off[EXP_W-1:0], mant_r[MANT_W-1:0]};
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (s2_zero) begin
      res = {s2_sign, {(W-1){1'b0}}};
    end else if (under) begin
      res     = {s2_sign, {(W-1){1'b0}}};
      res_unf = 1'b1;
    end else if (over) begin
      res     = {s2_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      res_ovf = 1'b1;
    end
  end

  // S3: output register, held while the consumer is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      prod      <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (advance) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        prod <= res;
        ovf  <= res_ovf;
        unf  <= res_unf;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: vector table, latency, backpressure and reset sequences
// for fp_mult_pipe at default parameters, with an expected-result queue.

module tb_fp_mult_pipe;

  localparam int EXP_W  = 7;
  localparam int MANT_W = 16;
  localparam int BIAS   = 63;
  localparam int W      = 1 + EXP_W + MANT_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] prod;
  logic         ovf;
  logic         unf;

  int tests = 0;
  int fails = 0;
  int pops  = 0;
  logic last_ov;
  logic acc;

  // scoreboard: {prod, ovf, unf}
  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         o;
    logic         u;
  } vec_t;

  vec_t tbl[12];

  fp_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .ovf       (ovf),
    .unf       (unf)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- checks ----------------
  task automatic check_bit(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic s;
    longint unsigned fx, fy, p, keep;
    int e, sh;
    logic [EXP_W-1:0]  ef;
    logic [MANT_W-1:0] mf;
    s = x[W-1] ^ y[W-1];
    if (x[W-2:0] == '0 || y[W-2:0] == '0)
      return {s, {(W-1){1'b0}}, 2'b00};
    fx = (64'd1 << MANT_W) | 64'(x[MANT_W-1:0]);
    fy = (64'd1 << MANT_W) | 64'(y[MANT_W-1:0]);
    p  = fx * fy;
    e  = int'(x[W-2 -: EXP_W]) + int'(y[W-2 -: EXP_W]);
    if (p >= (64'd1 << (2*MANT_W+1))) begin
      sh = MANT_W + 1;
      e  = e + 1;
    end else begin
      sh = MANT_W;
    end
    keep = p >> sh;
`ifdef FP_MULT_ROUND_EN
    begin
      longint unsigned rem, half;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 64'd1;
      if (keep == (64'd1 << (MANT_W+1))) begin
        keep = keep >> 1;
        e    = e + 1;
      end
    end
`endif
    if (e < BIAS)
      return {s, {(W-1){1'b0}}, 2'b01};
    if (e - BIAS > (1 << EXP_W) - 1)
      return {s, {EXP_W{1'b1}}, {MANT_W{1'b0}}, 2'b10};
    ef = EXP_W'(e - BIAS);
    mf = keep[MANT_W-1:0];
    return {s, ef, mf, 2'b00};
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [EXP_W-1:0]  ex;
    logic [MANT_W-1:0] mt;
    logic              sg;
    sg = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 15) == 0) return {sg, {(W-1){1'b0}}};
    ex = EXP_W'($urandom_range(20, 110));
    mt = MANT_W'($urandom());
    return {sg, ex, mt};
  endfunction

  // ---------------- driver ----------------
  // One clock: drive at the falling edge, observe 1ns later; any transfer
  // then happens at the following rising edge.
  task automatic cycle(input logic rst_v, input logic iv, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic ordy, output logic accepted);
    logic [W+1:0] e;
    @(negedge clk);
    rst       = rst_v;
    in_valid  = iv;
    a         = av;
    b         = bv;
    out_ready = ordy;
    #1;
    check_bit("in_ready", in_ready, !(out_valid && !out_ready));
    last_ov = out_valid;
    if (!rst_v && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got prod=%h with nothing pending", prod);
      end else begin
        e = exp_q.pop_front();
        check_word("prod", prod, e[W+1:2]);
        check_bit("ovf", ovf, e[1]);
        check_bit("unf", unf, e[0]);
        pops++;
      end
    end
    accepted = !rst_v && iv && in_ready;
  endtask

  task automatic drain(input string tag);
    int n;
    logic acc_d;
    n = 0;
    while (exp_q.size() > 0 && n < 60) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, acc_d);
      n++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_drain: %0d results pending, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic latency_check(input string tag, input logic [W-1:0] x,
                               input logic [W-1:0] y, input logic [W+1:0] expv);
    logic acc_l;
    cycle(1'b0, 1'b1, x, y, 1'b1, acc_l);
    check_bit({tag, "_accept"}, acc_l, 1'b1);
    if (acc_l) exp_q.push_back(expv);
    for (int k = 0; k < 2; k++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, acc_l);
      check_bit({tag, "_early"}, last_ov, 1'b0);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1, acc_l);
    check_bit({tag, "_lat3"}, last_ov, 1'b1);
    check_bit({tag, "_popped"}, exp_q.size() == 0, 1'b1);
    exp_q.delete();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0]  = '{24'h3F8000, 24'h3F8000, 24'h402000, 1'b0, 1'b0};
    tbl[1]  = '{24'hC00000, 24'h3F8000, 24'hC08000, 1'b0, 1'b0};
    tbl[2]  = '{24'h000000, 24'h3F0000, 24'h000000, 1'b0, 1'b0};
    tbl[3]  = '{24'h7F0000, 24'h7F0000, 24'h7F0000, 1'b1, 1'b0};
    tbl[4]  = '{24'h010000, 24'h010000, 24'h000000, 1'b0, 1'b1};
`ifdef FP_MULT_ROUND_EN
    tbl[5]  = '{24'h3F0001, 24'h3F8000, 24'h3F8002, 1'b0, 1'b0};
`else
    tbl[5]  = '{24'h3F0001, 24'h3F8000, 24'h3F8001, 1'b0, 1'b0};
`endif
    tbl[6]  = '{24'h800000, 24'h3F8000, 24'h800000, 1'b0, 1'b0};
    tbl[7]  = '{24'h810000, 24'h010000, 24'h800000, 1'b0, 1'b1};
    tbl[8]  = '{24'hFF0000, 24'h7F0000, 24'hFF0000, 1'b1, 1'b0};
    tbl[9]  = '{24'h3F0000, 24'h7F0000, 24'h7F0000, 1'b0, 1'b0};
    tbl[10] = '{24'h010000, 24'h3E0000, 24'h000000, 1'b0, 1'b0};
    tbl[11] = '{24'h010000, 24'h3D0000, 24'h000000, 1'b0, 1'b1};

    // reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_bit("reset_in_ready", in_ready, 1'b1);
    check_word("reset_prod", prod, '0);
    check_bit("reset_ovf", ovf, 1'b0);
    check_bit("reset_unf", unf, 1'b0);

    // latency of the first transfer
    latency_check("lat", 24'h3F8000, 24'h3F8000, {24'h402000, 2'b00});

    // vector table, back to back
    for (int i = 0; i < 12; i++) begin
      cycle(1'b0, 1'b1, tbl[i].a, tbl[i].b, 1'b1, acc);
      check_bit("tbl_accept", acc, 1'b1);
      if (acc) exp_q.push_back({tbl[i].p, tbl[i].o, tbl[i].u});
    end
    drain("tbl");

    // sustained throughput, random operands
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] x, y;
      x = rand_op();
      y = rand_op();
      cycle(1'b0, 1'b1, x, y, 1'b1, acc);
      check_bit("thru_accept", acc, 1'b1);
      if (acc) exp_q.push_back(model(x, y));
    end
    drain("thru");

    // backpressure: 10 pairs, out_ready low on cycles 4..8 then random
    begin
      int sent, cyc, pops0;
      logic ordy;
      logic [W-1:0] x, y;
      sent  = 0;
      cyc   = 0;
      pops0 = pops;
      x = rand_op();
      y = rand_op();
      while ((sent < 10 || exp_q.size() > 0) && cyc < 300) begin
        ordy = (cyc >= 4 && cyc <= 8) ? 1'b0 : 1'($urandom_range(0, 1));
        cycle(1'b0, sent < 10, x, y, ordy, acc);
        if (acc) begin
          exp_q.push_back(model(x, y));
          sent++;
          x = rand_op();
          y = rand_op();
        end
        cyc++;
      end
      tests++;
      if (cyc >= 300) begin
        fails++;
        $display("FAIL bp_budget: sent %0d pending %0d, expected 10 sent and 0 pending", sent, exp_q.size());
        exp_q.delete();
      end
      check_word("bp_count", W'(pops - pops0), W'(10));
    end

    // reset with three results in flight
    for (int k = 0; k < 3; k++) begin
      logic [W-1:0] x, y;
      x = rand_op();
      y = rand_op();
      cycle(1'b0, 1'b1, x, y, 1'b1, acc);
      check_bit("rst_fill_accept", acc, 1'b1);
      if (acc) exp_q.push_back(model(x, y));
    end
    cycle(1'b1, 1'b1, 24'h3F8000, 24'h3F8000, 1'b1, acc);
    exp_q.delete();
    cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
    check_bit("rst_out_valid", last_ov, 1'b0);
    check_word("rst_prod", prod, '0);
    check_bit("rst_ovf", ovf, 1'b0);
    check_bit("rst_unf", unf, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, acc);
      check_bit("rst_no_stale", last_ov, 1'b0);
    end
    latency_check("post_rst", 24'hC00000, 24'h3F8000, {24'hC08000, 2'b00});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
